// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Arbitrates two write-back requesters onto the single register-file write
//   port. req0 (in-order ALU pipe) has fixed priority. req1 (multicycle/load
//   unit) is protected by a starvation counter. When req1 has lost
//   STARVE_LIMIT unstalled cycles in a row, the next cycle is reserved for it.
//   The winning beat is registered into a one-deep output stage, so latency is
//   one cycle. wb_sel drives the 2:1 write-back data mux.
//
//   Optional feature macro: WB_ZERO_FILTER_EN
//     When defined, a beat addressed to register 0 is accepted as normal but
//     is never presented as a valid write.
//
// Ports
//   clk                 clock, all state on rising edge
//   rst_n               asynchronous active-low reset
//   wb_stall            freeze output stage, grant nothing
//   req0_valid/ready    req0 handshake (ready is combinational)
//   req0_addr/data      req0 destination register / write data
//   req1_valid/ready    req1 handshake (ready is combinational)
//   req1_addr/data      req1 destination register / write data
//   wb_valid            registered write-port enable
//   wb_addr/data        registered write index / data
//   wb_sel              registered mux select: 0=req0, 1=req1
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_stall,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_sel
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        PRI0   = 1'b0,
        FORCE1 = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;

    logic              grant0, grant1, xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              beat_valid;

    // Grant and next-state logic.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant0         = 1'b0;
        grant1         = 1'b0;
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;

        if (!wb_stall) begin
            unique case (state)
                PRI0: begin
                    grant0 = req0_valid;
                    grant1 = !req0_valid && req1_valid;
                end
                FORCE1: begin
                    grant1 = req1_valid;
                end
                default: ;
            endcase

            // Count lost cycles of a waiting req1; clear on its transfer or withdrawal.
            if (!req1_valid || grant1)
                starve_cnt_nxt = '0;
            else if (starve_cnt != CNT_MAX)
                starve_cnt_nxt = starve_cnt + 1'b1;

            unique case (state)
                // Reserve the next cycle once the count reaches the limit at this edge.
                PRI0:    if (starve_cnt_nxt == CNT_MAX) state_nxt = FORCE1;
                // Unstalled FORCE1 always lasts one cycle: either req1 transfers or it left.
                FORCE1:  state_nxt = PRI0;
                default: state_nxt = PRI0;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 || grant1;
    assign sel_addr   = grant1 ? req1_addr : req0_addr;
    assign sel_data   = grant1 ? req1_data : req0_data;

`ifdef WB_ZERO_FILTER_EN
    // Register 0 is hardwired; accept the beat but never raise the write enable.
    assign beat_valid = xfer && (sel_addr != '0);
`else
    assign beat_valid = xfer;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PRI0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Output stage. The datapath is reset too so a beat in flight at reset
    // can never surface as a write afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_sel   <= 1'b0;
        end else if (!wb_stall) begin
            wb_valid <= beat_valid;
            if (xfer) begin
                wb_addr <= sel_addr;
                wb_data <= sel_data;
                wb_sel  <= grant1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Directed bench for wb_port_arbiter (STARVE_LIMIT=4). Inputs are driven
//   1 time unit after the rising edge. Combinational readies are checked
//   after a further settle delay. Registered outputs are checked just after
//   the next rising edge. Define WB_ZERO_FILTER_EN for both DUT and bench to
//   exercise the filtered build.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wb_stall;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              wb_valid, wb_sel;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_stall   (wb_stall),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_sel     (wb_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One unstalled cycle with the inputs already driven. The expected grant is
    // given by the caller. The registered beat is checked after the edge.
    task automatic beat(input string tag, input logic e0, input logic e1);
        #1;
        check({tag, " req0_ready"}, 64'(req0_ready), 64'(e0));
        check({tag, " req1_ready"}, 64'(req1_ready), 64'(e1));
        tick();
        check({tag, " wb_valid"}, 64'(wb_valid), 64'(e0 || e1));
        if (e0 || e1) begin
            check({tag, " wb_sel"},  64'(wb_sel),  64'(e1));
            check({tag, " wb_addr"}, 64'(wb_addr), 64'(e1 ? req1_addr : req0_addr));
            check({tag, " wb_data"}, 64'(wb_data), 64'(e1 ? req1_data : req0_data));
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wb_stall   = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_sel;

        rst_n = 1'b0;
        idle_inputs();
        req0_addr = '0; req0_data = '0;
        req1_addr = '0; req1_data = '0;

        // 1: reset state, then reset asserted mid-beat.
        #3;
        check("rst wb_valid", 64'(wb_valid), 64'd0);
        check("rst wb_addr",  64'(wb_addr),  64'd0);
        check("rst wb_data",  64'(wb_data),  64'd0);
        check("rst wb_sel",   64'(wb_sel),   64'd0);
        #9 rst_n = 1'b1;
        tick();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAAAA_0001;
        #1;
        check("midbeat req0_ready", 64'(req0_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst wb_valid", 64'(wb_valid), 64'd0);
        tick();
        check("inrst wb_valid", 64'(wb_valid), 64'd0);
        check("inrst wb_addr",  64'(wb_addr),  64'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("postrst wb_valid", 64'(wb_valid), 64'd0);
        check("postrst wb_addr",  64'(wb_addr),  64'd0);

        // 2: single req1 beat, then idle (addr/data hold).
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h1234_5678;
        beat("single1", 1'b0, 1'b1);
        req1_valid = 1'b0;
        tick();
        check("single1 idle wb_valid", 64'(wb_valid), 64'd0);
        check("single1 hold wb_addr",  64'(wb_addr),  64'd7);
        check("single1 hold wb_data",  64'(wb_data),  64'h1234_5678);

        // 3: continuous contention, 4:1 pattern over two periods.
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_00A1;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_00B2;
        exp_sel = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++)
            beat($sformatf("contend%0d", i), !exp_sel[i], exp_sel[i]);

        // 4: stall mid-sequence. Two req0 wins, 3 stalled cycles, then two
        // more req0 wins and the forced req1 grant.
        beat("prestall0", 1'b1, 1'b0);
        beat("prestall1", 1'b1, 1'b0);
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d req0_ready", i), 64'(req0_ready), 64'd0);
            check($sformatf("stall%0d req1_ready", i), 64'(req1_ready), 64'd0);
            tick();
            check($sformatf("stall%0d wb_valid", i), 64'(wb_valid), 64'd1);
            check($sformatf("stall%0d wb_sel", i),   64'(wb_sel),   64'd0);
            check($sformatf("stall%0d wb_addr", i),  64'(wb_addr),  64'd1);
        end
        wb_stall = 1'b0;
        beat("resume0", 1'b1, 1'b0);
        beat("resume1", 1'b1, 1'b0);
        beat("resume2", 1'b0, 1'b1);
        beat("resume3", 1'b1, 1'b0);

        // 7: FORCE1 abandoned when req1 withdraws. Here resume3 was win 1, so
        // three more wins reach the limit. No grant that cycle, then req0 resumes.
        for (int i = 0; i < 3; i++)
            beat($sformatf("pre_abandon%0d", i), 1'b1, 1'b0);
        req1_valid = 1'b0;
        beat("abandon", 1'b0, 1'b0);
        beat("after_abandon", 1'b1, 1'b0);
        req0_valid = 1'b0;
        tick();

        // 5: beat to register 0.
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFF_FFFF;
        #1;
        check("zero req0_ready", 64'(req0_ready), 64'd1);
        tick();
`ifdef WB_ZERO_FILTER_EN
        check("zero wb_valid", 64'(wb_valid), 64'd0);
`else
        check("zero wb_valid", 64'(wb_valid), 64'd1);
        check("zero wb_addr",  64'(wb_addr),  64'd0);
        check("zero wb_data",  64'(wb_data),  64'hFFFF_FFFF);
`endif

        // 6: back-to-back req0 beats to registers 1, 2, 3.
        for (int i = 1; i <= 3; i++) begin
            req0_addr = ADDR_W'(i);
            req0_data = 32'hC000_0000 + 32'(i);
            beat($sformatf("b2b%0d", i), 1'b1, 1'b0);
        end
        req0_valid = 1'b0;
        tick();
        check("b2b end wb_valid", 64'(wb_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
